// File: rtl/window_stream_gen_pkg.sv
// Shared types and helpers for the raster-to-window stream generator.
// Default geometry, FSM state encoding and window element indexing.
package window_stream_gen_pkg;

    localparam int WIN_HW_DEF = 3;
    localparam int DATA_W_DEF = 8;
    localparam int IMG_W_DEF  = 640;
    localparam int IMG_H_DEF  = 480;

    localparam int XW   = $clog2(IMG_W_DEF);
    localparam int YW   = $clog2(IMG_H_DEF);
    localparam int WINW = WIN_HW_DEF * WIN_HW_DEF * DATA_W_DEF;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic int win_idx(input int r, input int c, input int hw);
        return r * hw + c;
    endfunction

endpackage

// File: rtl/window_stream_gen_line_buffer_ram.sv
// One raster line of pixel storage.
// Asynchronous read, synchronous write, no reset on contents.
module line_buffer_ram #(
    parameter int DEPTH = 640,
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_addr,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    assign o_rdata = r_mem[i_addr];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

endmodule

// File: rtl/window_stream_gen.sv
// Raster pixel stream to packed winHW x winHW window stream.
// Line buffers feed a shift window; one-deep registered output stage.
import window_stream_gen_pkg::*;

module window_stream_gen #(
    parameter int winHW    = WIN_HW_DEF,
    parameter int winDataW = DATA_W_DEF,
    parameter int imgW     = IMG_W_DEF,
    parameter int imgH     = IMG_H_DEF
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [winDataW-1:0]               in_data,
    input  logic                              in_sof,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [winHW*winHW*winDataW-1:0]   window,
    output logic [$clog2(imgW)-1:0]           out_x,
    output logic [$clog2(imgH)-1:0]           out_y,
    output logic                              out_last
);

    localparam int LXW   = $clog2(imgW);
    localparam int LYW   = $clog2(imgH);
    localparam int LWINW = winHW * winHW * winDataW;

    localparam logic [LXW-1:0] X_FIRST  = LXW'(winHW - 1);
    localparam logic [LXW-1:0] X_LAST   = LXW'(imgW - 1);
    localparam logic [LYW-1:0] Y_FILLED = LYW'(winHW - 2);
    localparam logic [LYW-1:0] Y_LAST   = LYW'(imgH - 1);

    state_t             r_state;
    logic [LXW-1:0]     r_x;
    logic [LYW-1:0]     r_y;
    logic [LWINW-1:0]   r_shift;
    logic [LWINW-1:0]   r_window;
    logic               r_out_valid;
    logic [LXW-1:0]     r_out_x;
    logic [LYW-1:0]     r_out_y;
    logic               r_out_last;

    logic               w_accept;
    logic               w_emit;
    logic [LXW-1:0]     w_px;
    logic [LYW-1:0]     w_py;
    state_t             w_state;
    logic [LWINW-1:0]   w_shift_nxt;
    logic [winDataW-1:0] w_rd  [winHW-1];
    logic [winDataW-1:0] w_col [winHW];

    assign in_ready  = !r_out_valid || out_ready;
    assign out_valid = r_out_valid;
    assign window    = r_window;
    assign out_x     = r_out_x;
    assign out_y     = r_out_y;
    assign out_last  = r_out_last;

    assign w_accept = in_valid && in_ready;
    assign w_px     = in_sof ? '0 : r_x;
    assign w_py     = in_sof ? '0 : r_y;
    assign w_state  = in_sof ? ST_FILL : r_state;
    assign w_emit   = w_accept && (w_state == ST_RUN) && (w_px >= X_FIRST);

    // lb[0] holds the previous line, lb[winHW-2] the oldest one
    for (genvar k = 0; k < winHW - 1; k++) begin : g_lb
        logic [winDataW-1:0] w_wdata;
        if (k == 0) begin : g_head
            assign w_wdata = in_data;
        end else begin : g_chain
            assign w_wdata = w_rd[k-1];
        end
        line_buffer_ram #(
            .DEPTH (imgW),
            .WIDTH (winDataW),
            .AW    (LXW)
        ) u_lb (
            .i_clk   (clk),
            .i_we    (w_accept),
            .i_addr  (w_px),
            .i_wdata (w_wdata),
            .o_rdata (w_rd[k])
        );
    end

    always_comb begin
        w_col[winHW-1] = in_data;
        for (int r = 0; r < winHW - 1; r++) begin
            w_col[r] = w_rd[winHW-2-r];
        end
        w_shift_nxt = r_shift;
        for (int r = 0; r < winHW; r++) begin
            for (int c = 0; c < winHW; c++) begin
                if (c < winHW - 1) begin
                    w_shift_nxt[win_idx(r, c, winHW)*winDataW +: winDataW] =
                        r_shift[win_idx(r, c + 1, winHW)*winDataW +: winDataW];
                end else begin
                    w_shift_nxt[win_idx(r, c, winHW)*winDataW +: winDataW] = w_col[r];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_FILL;
            r_x         <= '0;
            r_y         <= '0;
            r_shift     <= '0;
            r_window    <= '0;
            r_out_valid <= 1'b0;
            r_out_x     <= '0;
            r_out_y     <= '0;
            r_out_last  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_shift <= w_shift_nxt;
                if (w_px == X_LAST) begin
                    r_x <= '0;
                    r_y <= (w_py == Y_LAST) ? '0 : w_py + 1'b1;
                end else begin
                    r_x <= w_px + 1'b1;
                    r_y <= w_py;
                end
                unique case (1'b1)
                    (w_state == ST_FILL): begin
                        if (w_px == X_LAST && w_py == Y_FILLED) r_state <= ST_RUN;
                        else                                    r_state <= ST_FILL;
                    end
                    default: begin
                        if (w_px == X_LAST && w_py == Y_LAST) r_state <= ST_FILL;
                        else                                  r_state <= ST_RUN;
                    end
                endcase
            end
            if (w_emit) begin
                r_out_valid <= 1'b1;
                r_window    <= w_shift_nxt;
                r_out_x     <= w_px;
                r_out_y     <= w_py;
                r_out_last  <= (w_px == X_LAST) && (w_py == Y_LAST);
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_window_stream_gen.sv
// Scoreboard bench for window_stream_gen: 3x3 on 4x4 and 5x5 on 8x6.
// Expected windows come from a bench-side image memory per DUT.
module tb_window_stream_gen;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         iv3, ir3, is3, ov3, or3, ol3;
    logic [7:0]   id3;
    logic [71:0]  win3;
    logic [1:0]   ox3, oy3;

    logic         iv5, ir5, is5, ov5, or5, ol5;
    logic [7:0]   id5;
    logic [199:0] win5;
    logic [2:0]   ox5;
    logic [2:0]   oy5;

    window_stream_gen #(.winHW(3), .winDataW(8), .imgW(4), .imgH(4)) d3 (
        .clk(clk), .rst(rst), .in_valid(iv3), .in_ready(ir3),
        .in_data(id3), .in_sof(is3), .out_valid(ov3), .out_ready(or3),
        .window(win3), .out_x(ox3), .out_y(oy3), .out_last(ol3)
    );

    window_stream_gen #(.winHW(5), .winDataW(8), .imgW(8), .imgH(6)) d5 (
        .clk(clk), .rst(rst), .in_valid(iv5), .in_ready(ir5),
        .in_data(id5), .in_sof(is5), .out_valid(ov5), .out_ready(or5),
        .window(win5), .out_x(ox5), .out_y(oy5), .out_last(ol5)
    );

    typedef struct {
        logic [199:0] win;
        int           x;
        int           y;
        bit           last;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    logic [7:0] img [2][8][8];
    int mx[2];
    int my[2];
    int n_assert = 0;
    int n_fail   = 0;
    int nwin[2];
    int nlast[2];

    task automatic check(input string tag, input logic [199:0] obs,
                         input logic [199:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model(input int id, input logic [7:0] d, input bit sof);
        int hw;
        int w;
        int h;
        exp_t e;
        hw = (id == 1) ? 5 : 3;
        w  = (id == 1) ? 8 : 4;
        h  = (id == 1) ? 6 : 4;
        if (sof) begin
            mx[id] = 0;
            my[id] = 0;
        end
        img[id][my[id]][mx[id]] = d;
        if (mx[id] >= hw - 1 && my[id] >= hw - 1) begin
            e.win = '0;
            for (int r = 0; r < hw; r++)
                for (int c = 0; c < hw; c++)
                    e.win[(r*hw+c)*8 +: 8] =
                        img[id][my[id]-hw+1+r][mx[id]-hw+1+c];
            e.x = mx[id];
            e.y = my[id];
            e.last = (mx[id] == w - 1) && (my[id] == h - 1);
            if (id == 1) q1.push_back(e);
            else         q0.push_back(e);
        end
        if (mx[id] == w - 1) begin
            mx[id] = 0;
            my[id] = (my[id] == h - 1) ? 0 : my[id] + 1;
        end else begin
            mx[id] = mx[id] + 1;
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && ov3 && or3) begin
            if (q0.size() == 0) begin
                check("d3_extra_window", 1, 0);
            end else begin
                e = q0.pop_front();
                check("d3_window", win3, e.win);
                check("d3_out_x", ox3, e.x);
                check("d3_out_y", oy3, e.y);
                check("d3_out_last", ol3, e.last);
                nwin[0]++;
                if (ol3) nlast[0]++;
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && ov5 && or5) begin
            if (q1.size() == 0) begin
                check("d5_extra_window", 1, 0);
            end else begin
                e = q1.pop_front();
                check("d5_window", win5, e.win);
                check("d5_out_x", ox5, e.x);
                check("d5_out_y", oy5, e.y);
                check("d5_out_last", ol5, e.last);
                nwin[1]++;
                if (ol5) nlast[1]++;
            end
        end
    end

    task automatic send3(input logic [7:0] d, input bit sof);
        int n;
        iv3 = 1'b1;
        id3 = d;
        is3 = sof;
        n = 0;
        @(negedge clk);
        while (!ir3 && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("d3_in_ready_timeout", ir3, 1);
        if (ir3) model(0, d, sof);
        @(posedge clk);
        #1;
        iv3 = 1'b0;
        is3 = 1'b0;
    endtask

    task automatic frame3(input int base, input bit sof, input int first,
                          input int last, input int stall_at);
        for (int i = first; i <= last; i++) begin
            send3(8'(base + i), sof && (i == first));
            if (i == stall_at) begin
                or3 = 1'b0;
                iv3 = 1'b1;
                id3 = 8'(base + i + 1);
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    check("stall_in_ready", ir3, 0);
                    check("stall_out_valid", ov3, 1);
                    check("stall_window", win3,
                          (q0.size() > 0) ? q0[0].win : '1);
                    check("stall_out_x", ox3, 3);
                    check("stall_out_y", oy3, 2);
                    @(posedge clk);
                    #1;
                end
                or3 = 1'b1;
            end
        end
    endtask

    task automatic send5(input logic [7:0] d, input bit sof);
        int n;
        repeat ($urandom_range(0, 2)) begin
            iv5 = 1'b0;
            or5 = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        iv5 = 1'b1;
        id5 = d;
        is5 = sof;
        or5 = 1'($urandom_range(0, 1));
        n = 0;
        @(negedge clk);
        while (!ir5 && n < 50) begin
            @(posedge clk);
            #1;
            or5 = 1'($urandom_range(0, 1));
            n++;
            @(negedge clk);
        end
        check("d5_in_ready_timeout", ir5, 1);
        if (ir5) model(1, d, sof);
        @(posedge clk);
        #1;
        iv5 = 1'b0;
        is5 = 1'b0;
    endtask

    task automatic drain(input int id);
        int n;
        n = 0;
        if (id == 1) or5 = 1'b1;
        while (((id == 1) ? q1.size() : q0.size()) != 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_queue_empty", (id == 1) ? q1.size() : q0.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int w0;
        int l0;
        rst = 1'b1;
        iv3 = 1'b0; id3 = '0; is3 = 1'b0; or3 = 1'b1;
        iv5 = 1'b0; id5 = '0; is5 = 1'b0; or5 = 1'b1;
        mx = '{0, 0};
        my = '{0, 0};
        nwin = '{0, 0};
        nlast = '{0, 0};
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", ov3, 0);
        check("rst_window", win3, 0);
        check("rst_out_x", ox3, 0);
        check("rst_out_y", oy3, 0);
        check("rst_out_last", ol3, 0);
        check("rst_in_ready", ir3, 1);
        check("rst_d5_out_valid", ov5, 0);
        @(posedge clk);
        #1;

        // test 1: single frame, free flow
        w0 = nwin[0]; l0 = nlast[0];
        frame3(0, 1'b1, 0, 15, -1);
        drain(0);
        check("t1_windows", nwin[0] - w0, 4);
        check("t1_last", nlast[0] - l0, 1);

        // test 2: consumer stall at window (3,2)
        w0 = nwin[0]; l0 = nlast[0];
        frame3(0, 1'b1, 0, 15, 11);
        drain(0);
        check("t2_windows", nwin[0] - w0, 4);
        check("t2_last", nlast[0] - l0, 1);

        // test 3: back-to-back frames with distinct pixel values
        w0 = nwin[0]; l0 = nlast[0];
        frame3(20, 1'b1, 0, 15, -1);
        frame3(60, 1'b1, 0, 15, -1);
        drain(0);
        check("t3_windows", nwin[0] - w0, 8);
        check("t3_last", nlast[0] - l0, 2);

        // test 4: sof mid-frame at (1,2)
        w0 = nwin[0]; l0 = nlast[0];
        frame3(0, 1'b1, 0, 9, -1);
        frame3(100, 1'b1, 0, 15, -1);
        drain(0);
        check("t4_windows", nwin[0] - w0, 4);
        check("t4_last", nlast[0] - l0, 1);

        // test 5: reset mid-frame, then a frame without sof
        frame3(0, 1'b1, 0, 9, -1);
        rst = 1'b1;
        mx = '{0, 0};
        my = '{0, 0};
        q0.delete();
        q1.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("t5_out_valid", ov3, 0);
        check("t5_in_ready", ir3, 1);
        check("t5_window", win3, 0);
        @(posedge clk);
        #1;
        w0 = nwin[0]; l0 = nlast[0];
        frame3(0, 1'b0, 0, 15, -1);
        drain(0);
        check("t5_windows", nwin[0] - w0, 4);
        check("t5_last", nlast[0] - l0, 1);

        // test 6: 5x5 on 8x6 with random handshakes
        for (int i = 0; i < 48; i++) begin
            send5(8'($urandom_range(0, 255)), i == 0);
        end
        drain(1);
        check("t6_windows", nwin[1], 8);
        check("t6_last", nlast[1], 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
